// File: rtl/mem_array_dp.sv
// Simple-dual-port memory: one write port with byte enables, one read port with a
// 1- or 2-stage output pipeline, selectable read-during-write policy and an init sweep.
module mem_array_dp #(
  parameter string                 MEM_TYPE   = "BRAM",
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    BYTE_WIDTH = 8,
  parameter int                    RD_LATENCY = 1,
  parameter string                 RDW_MODE   = "READ_FIRST",
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int                   NB         = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  ready,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [NB-1:0]         wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam bit MEM_TYPE_OK = (MEM_TYPE == "REG") || (MEM_TYPE == "LUT") || (MEM_TYPE == "BRAM");
  localparam bit RDW_OK      = (RDW_MODE == "READ_FIRST") || (RDW_MODE == "WRITE_FIRST");
  localparam bit WRITE_FIRST = (RDW_MODE == "WRITE_FIRST");

  if (!MEM_TYPE_OK) begin : g_bad_mem_type
    $fatal(1, "mem_array_dp: MEM_TYPE must be REG, LUT or BRAM");
  end
  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
    $fatal(1, "mem_array_dp: BYTE_WIDTH must divide DATA_WIDTH");
  end
  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $fatal(1, "mem_array_dp: RD_LATENCY must be 1 or 2");
  end
  if (!RDW_OK) begin : g_bad_rdw_mode
    $fatal(1, "mem_array_dp: RDW_MODE must be READ_FIRST or WRITE_FIRST");
  end

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic                    w_wr_fire;
  logic                    w_rd_fire;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic [DATA_WIDTH-1:0]   r_pipe_data [RD_LATENCY+1];
  logic [RD_LATENCY:0]     r_pipe_vld;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the next-state value is defaulted first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (!clr && (r_ptr == ADDR_WIDTH'(DEPTH - 1))) w_state_nxt = ST_READY;
      ST_READY: if (clr) w_state_nxt = ST_INIT;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // Port strobes are gated off in INIT and in the cycle that requests a clear.
  always_comb begin
    ready     = (r_state == ST_READY);
    w_wr_fire = wr_en && ready && !clr;
    w_rd_fire = rd_en && ready && !clr;
  end

  // The pointer wraps to 0 on the last sweep edge, so READY starts with it cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_ptr <= '0;
    else if (clr)               r_ptr <= '0;
    else if (r_state == ST_INIT) r_ptr <= r_ptr + 1'b1;
  end

  // NOTE: the storage array has no reset; the init sweep defines its contents,
  // which keeps it mappable onto RAM primitives.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_ptr] <= INIT_VALUE;
    end else if (w_wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) r_mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // WRITE_FIRST forwards the enabled write lanes onto a same-address read.
  always_comb begin
    w_rd_word = r_mem[rd_addr];
    if (WRITE_FIRST && w_wr_fire && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Stage 0 captures the sampled word; stages only load behind a valid, so the
  // last stage holds rd_data steady while rd_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) r_pipe_data[i] <= '0;
    end else begin
      if (clr) r_pipe_vld <= '0;
      else     r_pipe_vld <= {r_pipe_vld[RD_LATENCY-1:0], w_rd_fire};
      if (w_rd_fire) r_pipe_data[0] <= w_rd_word;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        if (r_pipe_vld[i-1] && !clr) r_pipe_data[i] <= r_pipe_data[i-1];
      end
    end
  end

  assign rd_data  = r_pipe_data[RD_LATENCY];
  assign rd_valid = r_pipe_vld[RD_LATENCY];

endmodule

// File: tb/tb_mem_array_dp.sv
// Directed bench for mem_array_dp: a READ_FIRST/latency-1 instance and a
// WRITE_FIRST/latency-2 instance driven by the same stimulus.
module tb_mem_array_dp;

  localparam int          DW   = 32;
  localparam int          AW   = 4;
  localparam int          NB   = 4;
  localparam logic [31:0] INIT = 32'hA5A5A5A5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [NB-1:0] wr_be = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic          ready_rf, ready_wf, rd_valid_rf, rd_valid_wf;
  logic [DW-1:0] rd_data_rf, rd_data_wf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_array_dp #(
    .MEM_TYPE("BRAM"), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
    .RD_LATENCY(1), .RDW_MODE("READ_FIRST"), .INIT_VALUE(INIT)
  ) dut_rf (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready_rf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_rf), .rd_valid(rd_valid_rf)
  );

  mem_array_dp #(
    .MEM_TYPE("REG"), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
    .RD_LATENCY(2), .RDW_MODE("WRITE_FIRST"), .INIT_VALUE(INIT)
  ) dut_wf (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready_wf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_wf), .rd_valid(rd_valid_wf)
  );

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [NB-1:0] wr_be;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] exp_rf;
    logic [DW-1:0] exp_wf;
  } op_t;

  op_t         ops [13];
  logic [31:0] exp_lo [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
  endtask

  // One transaction in one cycle, then watch both read ports for the result.
  task automatic run_op(input op_t v, input string tag);
    bit got_rf = 1'b0;
    bit got_wf = 1'b0;
    @(negedge clk);
    wr_en = v.wr_en; wr_addr = v.wr_addr; wr_be = v.wr_be; wr_data = v.wr_data;
    rd_en = v.rd_en; rd_addr = v.rd_addr;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) idle();
      if (rd_valid_rf) begin
        check($sformatf("%s rf latency", tag), 32'(k), 32'd1);
        check($sformatf("%s rf data", tag), rd_data_rf, v.exp_rf);
        got_rf = 1'b1;
      end
      if (rd_valid_wf) begin
        check($sformatf("%s wf latency", tag), 32'(k), 32'd2);
        check($sformatf("%s wf data", tag), rd_data_wf, v.exp_wf);
        got_wf = 1'b1;
      end
    end
    check($sformatf("%s rf valid seen", tag), 32'(got_rf), 32'(v.rd_en));
    check($sformatf("%s wf valid seen", tag), 32'(got_wf), 32'(v.rd_en));
    check($sformatf("%s ready", tag), {30'd0, ready_rf, ready_wf}, 32'd3);
  endtask

  // Called right after the negedge preceding the first sweep edge.
  task automatic wait_ready(input string tag);
    int  first_rf = 0;
    int  first_wf = 0;
    bit  vld_seen = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ready_rf && first_rf == 0) first_rf = n;
      if (ready_wf && first_wf == 0) first_wf = n;
      if (rd_valid_rf || rd_valid_wf) vld_seen = 1'b1;
    end
    check($sformatf("%s rf edges to ready", tag), 32'(first_rf), 32'd16);
    check($sformatf("%s wf edges to ready", tag), 32'(first_wf), 32'd16);
    check($sformatf("%s no rd_valid", tag), 32'(vld_seen), 32'd0);
  endtask

  task automatic read_all(input string tag);
    op_t r;
    for (int a = 0; a < 16; a++) begin
      r = '{1'b0, '0, '0, '0, 1'b1, AW'(a), INIT, INIT};
      run_op(r, $sformatf("%s a%0d", tag, a));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s rf ready", tag), 32'(ready_rf), 32'd0);
    check($sformatf("%s wf ready", tag), 32'(ready_wf), 32'd0);
    check($sformatf("%s rf rd_valid", tag), 32'(rd_valid_rf), 32'd0);
    check($sformatf("%s wf rd_valid", tag), 32'(rd_valid_wf), 32'd0);
    check($sformatf("%s rf rd_data", tag), rd_data_rf, 32'd0);
    check($sformatf("%s wf rd_data", tag), rd_data_wf, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          wr_en wr_addr wr_be    wr_data        rd_en rd_addr exp_rf         exp_wf
    ops[0]  = '{1'b1, 4'd3,   4'hF,    32'h11223344,  1'b0, 4'd0,   32'h0,         32'h0};
    ops[1]  = '{1'b1, 4'd3,   4'b0101, 32'hAABBCCDD,  1'b0, 4'd0,   32'h0,         32'h0};
    ops[2]  = '{1'b0, 4'd0,   4'h0,    32'h0,         1'b1, 4'd3,   32'h11BB33DD,  32'h11BB33DD};
    ops[3]  = '{1'b1, 4'd5,   4'hF,    32'h00000000,  1'b0, 4'd0,   32'h0,         32'h0};
    ops[4]  = '{1'b1, 4'd5,   4'hF,    32'hDEADBEEF,  1'b1, 4'd5,   32'h00000000,  32'hDEADBEEF};
    ops[5]  = '{1'b0, 4'd0,   4'h0,    32'h0,         1'b1, 4'd5,   32'hDEADBEEF,  32'hDEADBEEF};
    ops[6]  = '{1'b1, 4'd7,   4'b0011, 32'h12345678,  1'b1, 4'd7,   32'hA5A5A5A5,  32'hA5A55678};
    ops[7]  = '{1'b1, 4'd8,   4'hF,    32'hFFFFFFFF,  1'b1, 4'd9,   32'hA5A5A5A5,  32'hA5A5A5A5};
    ops[8]  = '{1'b0, 4'd0,   4'h0,    32'h0,         1'b1, 4'd8,   32'hFFFFFFFF,  32'hFFFFFFFF};
    ops[9]  = '{1'b1, 4'd9,   4'h0,    32'h00000000,  1'b1, 4'd9,   32'hA5A5A5A5,  32'hA5A5A5A5};
    ops[10] = '{1'b0, 4'd0,   4'h0,    32'h0,         1'b1, 4'd9,   32'hA5A5A5A5,  32'hA5A5A5A5};
    ops[11] = '{1'b1, 4'd10,  4'b1000, 32'h00000000,  1'b0, 4'd0,   32'h0,         32'h0};
    ops[12] = '{1'b0, 4'd0,   4'h0,    32'h0,         1'b1, 4'd10,  32'h00A5A5A5,  32'h00A5A5A5};

    exp_lo = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11BB33DD,
               32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A55678};

    // Reset values, then the power-up sweep.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_ready("sweep");
    read_all("post-sweep");

    for (int i = 0; i < 13; i++) run_op(ops[i], $sformatf("vec%0d", i));

    // Back-to-back reads of 0..7; rf expects data at negedges 2..9, wf at 3..10.
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      check($sformatf("burst j%0d rf valid", j), 32'(rd_valid_rf), 32'(j >= 2 && j <= 9));
      check($sformatf("burst j%0d wf valid", j), 32'(rd_valid_wf), 32'(j >= 3 && j <= 10));
      if (j >= 2 && j <= 9)  check($sformatf("burst j%0d rf data", j), rd_data_rf, exp_lo[j-2]);
      if (j >= 3 && j <= 10) check($sformatf("burst j%0d wf data", j), rd_data_wf, exp_lo[j-3]);
      if (j >= 10)           check($sformatf("burst j%0d rf hold", j), rd_data_rf, exp_lo[7]);
      if (j < 8) begin
        rd_en = 1'b1; rd_addr = AW'(j);
      end else begin
        idle();
      end
    end

    // clr with reads in flight; the same-cycle write and read are dropped.
    @(negedge clk); rd_en = 1'b1; rd_addr = 4'd0;
    @(negedge clk); rd_addr = 4'd1;
    @(negedge clk);
    clr = 1'b1; rd_addr = 4'd2; wr_en = 1'b1; wr_addr = 4'd0; wr_be = 4'hF; wr_data = 32'h0;
    @(negedge clk);
    idle();
    check("clr rf ready", 32'(ready_rf), 32'd0);
    check("clr wf ready", 32'(ready_wf), 32'd0);
    check("clr rf rd_valid", 32'(rd_valid_rf), 32'd0);
    check("clr wf rd_valid", 32'(rd_valid_wf), 32'd0);
    wait_ready("clr sweep");
    read_all("post-clr");

    // Async reset between edges with a read in flight.
    @(negedge clk); rd_en = 1'b1; rd_addr = 4'd3;
    @(posedge clk);
    #2 rst = 1'b1;
    idle();
    #1 check_reset_outputs("async rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Interrupt the resulting sweep after 6 edges.
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("rst in sweep");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ready("restarted sweep");
    run_op('{1'b0, '0, '0, '0, 1'b1, 4'd0,  INIT, INIT}, "post-rst a0");
    run_op('{1'b0, '0, '0, '0, 1'b1, 4'd15, INIT, INIT}, "post-rst a15");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_array_dp.md
# mem_array_dp

Parametrised simple-dual-port memory with one write port and one read port, per-byte write enables, configurable read latency, and a selectable read-during-write policy. After reset, and on request, a hardware initialisation sweep clears the array to a known value. It is the general-purpose storage primitive for buffers, register files and lookup tables that need concurrent read and write access.

## Interface
- MEM_TYPE, "BRAM": implementation hint, one of "REG", "LUT" or "BRAM". Behaviour is identical for all three. Any other value causes `$fatal` at elaboration.
- DATA_WIDTH, 32: word width in bits.
- ADDR_WIDTH, 6: address width. DEPTH = 2^ADDR_WIDTH.
- BYTE_WIDTH, 8: lane width. NB = DATA_WIDTH/BYTE_WIDTH. Elaboration fails with `$fatal` unless BYTE_WIDTH divides DATA_WIDTH.
- RD_LATENCY, 1: read latency in cycles, 1 or 2. Any other value causes `$fatal`.
- RDW_MODE, "READ_FIRST": same-address read-during-write policy, "READ_FIRST" or "WRITE_FIRST".
- INIT_VALUE, 0: DATA_WIDTH-bit value written to every word by the sweep.

Ports:
- clk  in  1  the only clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  single-cycle request to re-run the init sweep.
- ready  out  1  high when the array accepts reads and writes.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_be  in  NB  byte enables. Bit i covers lane i, i.e. data bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle pulse marking rd_data valid.

## Operation
- **States:** INIT and READY.
- **Reset:** rst forces state INIT, sweep pointer 0, ready=0, rd_valid=0, rd_data=0, and clears all read-pipeline valid bits.
- **INIT:**
  - Each edge writes INIT_VALUE to the address held in the sweep pointer, then increments the pointer.
  - At the edge where the pointer equals DEPTH-1, the block moves to READY.
  - wr_en and rd_en are ignored in this state.
- **READY:**
  - clr=1 moves the block to INIT with pointer 0. Any write or read presented in the same cycle is dropped. Pipeline valid bits clear, so rd_valid=0 from the next edge.
  - clr=1 during INIT restarts the sweep at pointer 0.
- **Write:** wr_en && ready updates only the lanes of mem[wr_addr] whose wr_be bit is 1. wr_be=0 means no change.
- **Read:** rd_en && ready samples mem[rd_addr] and launches it into a RD_LATENCY-stage pipeline.
- **Read-during-write, same address, same cycle:**
  - READ_FIRST: the read returns the pre-write word.
  - WRITE_FIRST: the read returns the merged word (new lanes where wr_be=1, old lanes elsewhere).
- **Different addresses:** a read and a write to different addresses in the same cycle are independent.
- **Addressing:** all addresses are in range by construction. There is no out-of-range path.
- **rd_data hold:** rd_data keeps its last value while rd_valid=0.

## Timing
- **Reset values:** ready=0, rd_valid=0, rd_data=0.
- **Sweep length:** with rst deasserted before edge 0, the sweep writes addresses 0..DEPTH-1 on edges 0..DEPTH-1. ready is 1 after edge DEPTH-1.
- **Read latency:** a read accepted at edge N gives rd_valid=1 and rd_data valid after edge N+RD_LATENCY-1+1, i.e. RD_LATENCY edges later.
- **Read throughput:** one read per cycle. Back-to-back reads produce back-to-back rd_valid pulses.
- **Write visibility:** a write accepted at edge N is visible to any read accepted at edge N+1 or later, independent of RDW_MODE.
- **Reset mid-operation:** rst is honoured at any time, including during the sweep or with reads in flight. Pending reads are discarded and never signal rd_valid. Array contents are undefined until the following sweep completes.
- **clr and ready:** ready falls at the edge that samples clr=1.

## Test plan
- **Reset and sweep:** DATA_WIDTH=32, ADDR_WIDTH=4, INIT_VALUE=32'hA5A5A5A5. Release rst, wait for ready (exactly 16 edges), read all addresses -> every word returns 32'hA5A5A5A5 and ready never drops.
- **Byte enables:** write 32'h11223344 with be=4'hF to address 3, then 32'hAABBCCDD with be=4'b0101 -> read of address 3 returns 32'h11BB33DD.
- **Read-during-write:** same-cycle write of 32'hDEADBEEF (be=4'hF) and read of address 5, which holds 0 -> READ_FIRST returns 0; WRITE_FIRST returns 32'hDEADBEEF; the next read returns 32'hDEADBEEF in both modes.
- **Latency and throughput:** RD_LATENCY=2, reads of addresses 0..7 on consecutive cycles -> rd_valid high for 8 consecutive cycles starting 2 edges after the first read, with data in address order.
- **clr mid-stream:** assert clr with two reads in flight -> ready=0 and rd_valid=0 from the next edge; after 16 edges ready=1 and all words equal INIT_VALUE.
- **Async reset:** assert rst between edges during the sweep, hold for 3 cycles, release -> ready=0 immediately; the sweep restarts at address 0 and ready rises after 16 edges.
